count_ones_requester: RTL and testbench
=======================================

Name: count_ones_requester

Overview:
- Initiator side of the count_ones handshake (data/data_ready out; start/done/bit_count in).
- Takes words from an upstream valid/ready source, presents each to a count_ones unit and waits for start then done.
- Captures bit_count, returns word plus count downstream through a one-entry output register, and keeps a saturating running total of ones.

Parameters:
DATA_WIDTH, 4, width of words presented to the counter
COUNT_WIDTH, 3, width of bit_count; must be >= clog2(DATA_WIDTH+1)
TOTAL_WIDTH, 8, width of running ones total

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; all state cleared while low
in_valid  input  1  upstream word available
in_data  input  DATA_WIDTH  upstream word
in_ready  output  1  requester accepts in_data this cycle
data  output  DATA_WIDTH  word presented to counter
data_ready  output  1  word on data is valid for counter
start  input  1  counter has loaded the word (acknowledge)
done  input  1  counter result on bit_count is valid
bit_count  input  COUNT_WIDTH  ones count from counter
out_valid  output  1  result register full
out_ready  input  1  downstream accepts result
out_data  output  DATA_WIDTH  word that was counted
out_count  output  COUNT_WIDTH  its ones count
total  output  TOTAL_WIDTH  saturating sum of all reported counts
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset low, async): state=IDLE, data=0, data_ready=0, out_valid=0, out_data=0, out_count=0, total=0, busy=0, in_ready=0 while reset held.
- FSM states: IDLE, PRESENT, WAIT_DONE, REPORT.
- IDLE: in_ready=1 iff out_valid=0. On in_valid&in_ready, register data<=in_data, next state PRESENT. data_ready rises the cycle after acceptance.
- PRESENT: data_ready=1, data held stable. On start=1 go to WAIT_DONE; data_ready drops next cycle. start and done both high in PRESENT: treat as start, go to WAIT_DONE (done evaluated there).
- WAIT_DONE: data_ready=0, data held. On first cycle done=1: out_count<=bit_count, out_data<=data, out_valid<=1, total<=min(total+bit_count, 2^TOTAL_WIDTH-1), go to REPORT.
- REPORT: one cycle, busy=1; returns to IDLE. in_ready remains 0 until out_valid clears.
- Output handshake: out_valid cleared on out_valid&out_ready. The IDLE accept can occur in the same cycle out_valid clears only from the following cycle (in_ready registered-free but gated by current out_valid).
- Latency: in-accept to data_ready = 1 cycle; done sampled to out_valid = 1 cycle.
- Word with no ones: bit_count=0 reported normally; total unchanged.
- Saturation: total sticks at all-ones; further adds have no effect.
- No timeout: PRESENT/WAIT_DONE wait indefinitely for start/done.
- Reset mid-operation: abandons word, drops data_ready immediately (async), loses pending result.
- done high while not in WAIT_DONE: ignored.

Optional Feature:
COUNT_CHECK_EN
- Defined: adds output check_err (1 bit, reset 0). At done capture, compares bit_count with an internal popcount of data. On mismatch check_err pulses high one cycle with out_valid rise. The reported count is still the counter's value.
- Undefined: no check_err port, no popcount logic.

Decomposition:
- Shared package: FSM state encoding (2-bit enum IDLE=0, PRESENT=1, WAIT_DONE=2, REPORT=3), default width constants, and a saturating-add function.
- One natural sub-module: popcount_ref (combinational ones count of DATA_WIDTH word), instantiated only under COUNT_CHECK_EN and reusable by benches.

Test Plan:
- in_data=4'hf, responder start 2 cycles after data_ready, done 4 cycles later with bit_count=4 -> out_data=f, out_count=4, total=4, data_ready high exactly until cycle after start.
- Back-to-back 4'ha then 4'h5, out_ready=1 -> counts 2,2; total=4 after both; second data_ready 1 cycle after second accept.
- out_ready=0 held 10 cycles after first result -> in_ready=0 throughout, second word not taken, out_valid stays 1 with stable fields.
- reset low during WAIT_DONE for word 4'hb -> data_ready=0, out_valid=0, total=0 immediately; next word 4'h9 yields count 2.
- TOTAL_WIDTH=3, words 4'hf,4'hf -> total=4 then saturates at 7.
- COUNT_CHECK_EN, data 4'hc, responder returns bit_count=3 -> out_count=3, check_err=1 for one cycle; correct return 2 -> check_err=0.

Source files
------------

// File: rtl/count_ones_requester_pkg.sv
// Shared types, default widths and helpers for the count_ones requester.
package count_ones_requester_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 4;
   localparam int unsigned DEF_COUNT_WIDTH = 3;
   localparam int unsigned DEF_TOTAL_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESENT   = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_REPORT    = 2'd3
   } state_e;

   // Sum clamped to the largest value representable in 'width' bits.
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned width);
      logic [63:0] lim;
      logic [63:0] sum;
      lim = (64'd1 << width) - 64'd1;
      sum = a + b;
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/count_ones_requester_popcount_ref.sv
// Combinational reference ones count of a DATA_WIDTH word.
module popcount_ref
   import count_ones_requester_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]  data_i,
   output logic [COUNT_WIDTH-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         count_o = count_o + COUNT_WIDTH'(data_i[i]);
      end
   end

endmodule

// File: rtl/count_ones_requester.sv
// Initiator side of the count_ones handshake with a one-entry result register.
// Define COUNT_CHECK_EN to add check_err, which flags a counter result that disagrees with a local popcount.
module count_ones_requester
   import count_ones_requester_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
   parameter int unsigned TOTAL_WIDTH = DEF_TOTAL_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   in_ready,
   output logic [DATA_WIDTH-1:0]  data,
   output logic                   data_ready,
   input  logic                   start,
   input  logic                   done,
   input  logic [COUNT_WIDTH-1:0] bit_count,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [COUNT_WIDTH-1:0] out_count,
   output logic [TOTAL_WIDTH-1:0] total,
   output logic                   busy
`ifdef COUNT_CHECK_EN
  ,output logic                   check_err
`endif
);

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
   logic [TOTAL_WIDTH-1:0] total_q, total_d;
   logic                   accept, capture, out_pop;

   // reset gates in_ready so nothing is offered while the block is held in reset
   assign in_ready = reset && (state_q == ST_IDLE) && !out_valid_q;
   assign accept   = in_valid && in_ready;
   assign capture  = (state_q == ST_WAIT_DONE) && done;
   assign out_pop  = out_valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (accept) state_d = ST_PRESENT;
         ST_PRESENT:   if (start)  state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (done)   state_d = ST_REPORT;
         ST_REPORT:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d      = accept ? in_data : data_q;
      out_data_d  = capture ? data_q : out_data_q;
      out_count_d = capture ? bit_count : out_count_q;
      out_valid_d = capture ? 1'b1 : (out_pop ? 1'b0 : out_valid_q);
      total_d     = capture ? TOTAL_WIDTH'(sat_add(64'(total_q), 64'(bit_count), TOTAL_WIDTH))
                            : total_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         total_q     <= '0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         total_q     <= total_d;
      end
   end

   assign data       = data_q;
   assign data_ready = (state_q == ST_PRESENT);
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_count  = out_count_q;
   assign total      = total_q;
   assign busy       = (state_q != ST_IDLE);

`ifdef COUNT_CHECK_EN
   logic [COUNT_WIDTH-1:0] ref_count;
   logic                   check_err_q, check_err_d;

   popcount_ref #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_popcount (
      .data_i  (data_q),
      .count_o (ref_count)
   );

   assign check_err_d = capture && (ref_count != bit_count);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) check_err_q <= 1'b0;
      else        check_err_q <= check_err_d;
   end

   assign check_err = check_err_q;
`endif

endmodule

// File: tb/tb_count_ones_requester.sv
// Directed bench for count_ones_requester: a hand-driven counter responder plus a
// second instance with a 3-bit total that shares all stimulus to exercise saturation.
module tb_count_ones_requester;

   logic       clk, reset;
   logic       in_valid;
   logic [3:0] in_data;
   logic       start, done, out_ready;
   logic [2:0] bit_count;

   logic       in_ready, data_ready, out_valid, busy;
   logic [3:0] data, out_data;
   logic [2:0] out_count;
   logic [7:0] total;

   logic       in_ready_s, data_ready_s, out_valid_s, busy_s;
   logic [3:0] data_s, out_data_s;
   logic [2:0] out_count_s;
   logic [2:0] total_s;
`ifdef COUNT_CHECK_EN
   logic       check_err, check_err_s;
`endif

   int n_cmp = 0;
   int n_err = 0;

   count_ones_requester #(.DATA_WIDTH(4), .COUNT_WIDTH(3), .TOTAL_WIDTH(8)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .data(data), .data_ready(data_ready),
      .start(start), .done(done), .bit_count(bit_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .total(total), .busy(busy)
`ifdef COUNT_CHECK_EN
     ,.check_err(check_err)
`endif
   );

   count_ones_requester #(.DATA_WIDTH(4), .COUNT_WIDTH(3), .TOTAL_WIDTH(3)) u_dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_s), .data(data_s), .data_ready(data_ready_s),
      .start(start), .done(done), .bit_count(bit_count),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_count(out_count_s), .total(total_s), .busy(busy_s)
`ifdef COUNT_CHECK_EN
     ,.check_err(check_err_s)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Offer a word, then act as the counter: start after sdly cycles, done ddly cycles later.
   // With both=1 a bogus done is raised together with start and must be ignored.
   task automatic send_word(input logic [3:0] d, input logic [2:0] bc,
                            input int sdly, input int ddly, input bit both);
      int k;
      in_valid = 1'b1;
      in_data  = d;
      k = 0;
      while (!in_ready && k < 50) begin
         tick();
         k++;
      end
      chk("in_ready_before_accept", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("data_ready_after_accept", data_ready, 1'b1);
      chk("data_presented", data, d);
      chk("busy_present", busy, 1'b1);
      repeat (sdly) tick();
      chk("data_ready_held", data_ready, 1'b1);
      start = 1'b1;
      if (both) begin
         done      = 1'b1;
         bit_count = 3'd7;
      end
      tick();
      start = 1'b0;
      done  = 1'b0;
      chk("data_ready_after_start", data_ready, 1'b0);
      chk("data_held_wait", data, d);
      chk("out_valid_before_done", out_valid, 1'b0);
      repeat (ddly) tick();
      done      = 1'b1;
      bit_count = bc;
      tick();
      done      = 1'b0;
      bit_count = '0;
   endtask

   typedef struct {
      logic [3:0] d;
      logic [2:0] bc;
      int         sdly;
      int         ddly;
      bit         both;
      logic [7:0] etot;
      logic [2:0] etot3;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{4'hf, 3'd4, 2, 4, 1'b0, 8'd4,  3'd4};
      vecs[1] = '{4'hf, 3'd4, 1, 0, 1'b0, 8'd8,  3'd7};
      vecs[2] = '{4'ha, 3'd2, 0, 0, 1'b0, 8'd10, 3'd7};
      vecs[3] = '{4'h5, 3'd2, 0, 1, 1'b0, 8'd12, 3'd7};
      vecs[4] = '{4'h0, 3'd0, 3, 2, 1'b0, 8'd12, 3'd7};
      vecs[5] = '{4'h7, 3'd3, 0, 0, 1'b1, 8'd15, 3'd7};
      vecs[6] = '{4'h8, 3'd1, 1, 3, 1'b0, 8'd16, 3'd7};

      reset = 1'b0; in_valid = 1'b0; in_data = '0; start = 1'b0; done = 1'b0;
      bit_count = '0; out_ready = 1'b1;
      #2;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_data_ready", data_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_total", total, 8'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", data, 4'h0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("in_ready_after_reset", in_ready, 1'b1);
      tick();

      for (int i = 0; i < 7; i++) begin
         send_word(vecs[i].d, vecs[i].bc, vecs[i].sdly, vecs[i].ddly, vecs[i].both);
         chk("out_valid_result", out_valid, 1'b1);
         chk("out_data", out_data, vecs[i].d);
         chk("out_count", out_count, vecs[i].bc);
         chk("total", total, vecs[i].etot);
         chk("total_sat", total_s, vecs[i].etot3);
         chk("busy_report", busy, 1'b1);
         chk("in_ready_report", in_ready, 1'b0);
         tick();
         chk("out_valid_popped", out_valid, 1'b0);
         chk("busy_idle", busy, 1'b0);
         chk("in_ready_idle", in_ready, 1'b1);
      end

      // Backpressure: result held, next word must not be taken.
      out_ready = 1'b0;
      send_word(4'hc, 3'd2, 1, 1, 1'b0);
      chk("bp_total", total, 8'd18);
      in_valid = 1'b1;
      in_data  = 4'h3;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_out_data", out_data, 4'hc);
         chk("bp_out_count", out_count, 3'd2);
         chk("bp_data_ready", data_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_out_valid", out_valid, 1'b0);
      chk("bp_release_not_taken", data_ready, 1'b0);
      chk("bp_release_in_ready", in_ready, 1'b1);
      send_word(4'h3, 3'd2, 0, 0, 1'b0);
      chk("bp2_out_data", out_data, 4'h3);
      chk("bp2_total", total, 8'd20);
      tick();

      // done raised while idle is ignored.
      done = 1'b1;
      bit_count = 3'd5;
      tick();
      tick();
      done = 1'b0;
      bit_count = '0;
      chk("idle_done_out_valid", out_valid, 1'b0);
      chk("idle_done_total", total, 8'd20);
      chk("idle_done_busy", busy, 1'b0);

      // Asynchronous reset while waiting for done.
      in_valid = 1'b1;
      in_data  = 4'hb;
      tick();
      in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("mid_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("mid_rst_data_ready", data_ready, 1'b0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_total", total, 8'd0);
      chk("mid_rst_total_sat", total_s, 3'd0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      send_word(4'h9, 3'd2, 1, 1, 1'b0);
      chk("post_rst_count", out_count, 3'd2);
      chk("post_rst_data", out_data, 4'h9);
      chk("post_rst_total", total, 8'd2);
      tick();

`ifdef COUNT_CHECK_EN
      send_word(4'hc, 3'd3, 0, 1, 1'b0);
      chk("chk_bad_count", out_count, 3'd3);
      chk("chk_bad_err", check_err, 1'b1);
      chk("chk_total", total, 8'd5);
      tick();
      chk("chk_err_pulse", check_err, 1'b0);
      send_word(4'hc, 3'd2, 0, 1, 1'b0);
      chk("chk_good_err", check_err, 1'b0);
      chk("chk_good_total", total, 8'd7);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
